// File: rtl/mux41_pkg.sv
// mux41_pkg: shared types and helpers for the 4:1 stream merger.
// Provides the input count, select width, request/select types and a one-hot decoder.
package mux41_pkg;

  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NUM_IN-1:0] req_t;

  // Index of the set bit of a one-hot vector; 0 when no bit is set.
  function automatic sel_t onehot_to_idx(req_t oh);
    sel_t idx;
    idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (oh[i]) idx = sel_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: combinational 4-way arbiter producing an at-most-one-hot grant.
// Ports: req (request vector), ptr (highest-priority index), grant (one-hot).
// Build option MUX41_FIXED_PRIO_EN: fixed priority, input 0 highest, ptr ignored.
module rr_arb4
  import mux41_pkg::*;
(
  input  req_t req,
  input  sel_t ptr,
  output req_t grant
);

`ifdef MUX41_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

`else

  sel_t idx;

  // Scan from the farthest offset down so the
  // requester closest to ptr is the last writer.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = ptr + sel_t'(k);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/mux41_stream_arb.sv
// mux41_stream_arb: merges four valid/ready streams into one registered stream.
// Ports: clk, rst_n (async, active-low); in_valid/in_data/in_ready per source;
//        out_valid/out_data/out_sel/out_ready toward the sink.
// Build option MUX41_FIXED_PRIO_EN: fixed priority instead of round-robin.
module mux41_stream_arb
  import mux41_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  logic              can_load;
  logic              xfer;
  req_t              grant;
  sel_t              gidx;
  sel_t              ptr;
  logic [DATA_W-1:0] gdata;

  // Output slot is free when empty or being drained this cycle.
  assign can_load = !out_valid | out_ready;

`ifdef MUX41_FIXED_PRIO_EN
  assign ptr = '0;
`else
  sel_t rr_ptr;
  assign ptr = rr_ptr;
`endif

  rr_arb4 u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign in_ready = grant & {NUM_IN{can_load}};
  assign xfer     = |in_ready;
  assign gidx     = onehot_to_idx(grant);

  always_comb begin
    gdata = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) gdata = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (can_load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= gdata;
        out_sel  <= gidx;
      end
    end
  end

`ifndef MUX41_FIXED_PRIO_EN
  // Pointer moves just past the winner, wrapping 3 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= gidx + sel_t'(1);
    end
  end
`endif

endmodule
